// File: rtl/boot_reset_sequencer_pkg.sv
// Shared types and constants for the boot reset sequencer.
// The state enum encoding is visible on the state output port.
package boot_reset_pkg;

    typedef enum logic [1:0] {
        SYNC      = 2'd0,
        HOLD_SYS  = 2'd1,
        HOLD_CORE = 2'd2,
        RUN       = 2'd3
    } boot_state_e;

    localparam int BOOT_CNT_W = 8;

    // Width large enough to hold the terminal count of either hold phase.
    function automatic int cnt_width(input int cycles, input int core_delay);
        int m;
        m = (cycles > core_delay) ? cycles : core_delay;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/boot_reset_sequencer_if.sv
// Control/status bundle between the boot reset sequencer and its consumer.
// The sequencer takes the slave modport; the consumer takes master.
interface boot_reset_sequencer_if;
    import boot_reset_pkg::*;

    logic                  reset_req;
    logic                  reset_o;
    logic                  core_reset_o;
    logic                  done;
    logic [BOOT_CNT_W-1:0] boot_count;
    boot_state_e           state;

    modport master (
        output reset_req,
        input  reset_o, core_reset_o, done, boot_count, state
    );

    modport slave (
        input  reset_req,
        output reset_o, core_reset_o, done, boot_count, state
    );
endinterface

// File: rtl/boot_reset_sequencer_sync.sv
// Async-assert / sync-release flop chain for the active-low board reset.
// rel_n goes high STAGES clock edges after reset deasserts.
module reset_release_sync #(
    parameter int STAGES = 1
) (
    input  logic clk,
    input  logic reset,
    output logic rel_n
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic [STAGES:0]   shifted;

    always_comb begin
        shifted = {sync_q, 1'b1};
        sync_d  = shifted[STAGES-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign rel_n = sync_q[STAGES-1];
endmodule

// File: rtl/boot_reset_sequencer.sv
// Board power-on reset sequencer: synchronized release, stretched system
// reset, delayed core reset, re-boot request, boot counter.
module boot_reset_sequencer
    import boot_reset_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CYCLES      = 20,
    parameter int CORE_DELAY  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    boot_reset_sequencer_if.slave bus
);
    localparam int CNT_W = cnt_width(CYCLES, CORE_DELAY);
    localparam logic [CNT_W-1:0] SYS_LAST  = CNT_W'(CYCLES - 1);
    localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'((CORE_DELAY > 0) ? CORE_DELAY - 1 : 0);
    localparam logic [BOOT_CNT_W-1:0] BOOT_MAX = '1;

    logic rel_n;

    // The SYNC->HOLD_SYS state flop acts as the final synchronizer stage,
    // so the chain itself is one flop shorter than SYNC_STAGES.
    reset_release_sync #(.STAGES(SYNC_STAGES - 1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .rel_n (rel_n)
    );

    boot_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  reset_o_q, reset_o_d;
    logic                  core_reset_q, core_reset_d;
    logic                  done_q, done_d;
    logic [BOOT_CNT_W-1:0] boot_count_q, boot_count_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        boot_count_d = boot_count_q;

        case (state_q)
            SYNC: begin
                if (rel_n) begin
                    state_d = HOLD_SYS;
                    cnt_d   = '0;
                end
            end
            HOLD_SYS: begin
                if (cnt_q == SYS_LAST) begin
                    cnt_d   = '0;
                    state_d = (CORE_DELAY == 0) ? RUN : HOLD_CORE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD_CORE: begin
                if (cnt_q == CORE_LAST) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        // A re-boot request overrides any completion on the same edge.
        if (state_q != SYNC && bus.reset_req) begin
            state_d = HOLD_SYS;
            cnt_d   = '0;
        end

        if (state_d == RUN && state_q != RUN) begin
            done_d = 1'b1;
            if (boot_count_q != BOOT_MAX) boot_count_d = boot_count_q + 1'b1;
        end

        reset_o_d    = (state_d == SYNC) || (state_d == HOLD_SYS);
        core_reset_d = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SYNC;
            cnt_q        <= '0;
            reset_o_q    <= 1'b1;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            boot_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reset_o_q    <= reset_o_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            boot_count_q <= boot_count_d;
        end
    end

    assign bus.reset_o      = reset_o_q;
    assign bus.core_reset_o = core_reset_q;
    assign bus.done         = done_q;
    assign bus.boot_count   = boot_count_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_boot_reset_sequencer.sv
// Randomized bench for boot_reset_sequencer: two instances (CORE_DELAY 4 and 0)
// share stimulus and are checked every cycle against an edge-count model.
module tb_boot_reset_sequencer;
    localparam int S = 2;
    localparam int C = 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    boot_reset_sequencer_if bus0();
    boot_reset_sequencer_if bus1();

    boot_reset_sequencer #(.SYNC_STAGES(S), .CYCLES(C), .CORE_DELAY(4)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    boot_reset_sequencer #(.SYNC_STAGES(S), .CYCLES(C), .CORE_DELAY(0)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    // Model: n = edges since release, hs = edge at which the current hold
    // phase started (S after release, or the last accepted request edge).
    int dly[2] = '{4, 0};
    int n[2];
    int hs[2];
    int bc[2];
    bit in_rst;
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            n[i]  = 0;
            hs[i] = S;
            bc[i] = 0;
        end
    endtask

    task automatic model_edge(input bit req);
        if (in_rst) return;
        for (int i = 0; i < 2; i++) begin
            n[i]++;
            if (req && (n[i] - 1) >= S) hs[i] = n[i];
            if (n[i] - hs[i] == C + dly[i]) bc[i] = (bc[i] == 255) ? 255 : bc[i] + 1;
        end
    endtask

    task automatic check_one(input int i, input logic ro, input logic cr, input logic dn,
                             input logic [7:0] bcv, input logic [1:0] stv);
        int d;
        int st;
        d = n[i] - hs[i];
        if (in_rst || n[i] < S) st = 0;
        else if (d < C)         st = 1;
        else if (d < C + dly[i]) st = 2;
        else                    st = 3;
        chk($sformatf("u%0d.state", i),        32'(stv), 32'(st));
        chk($sformatf("u%0d.reset_o", i),      32'(ro),  32'(st <= 1));
        chk($sformatf("u%0d.core_reset_o", i), 32'(cr),  32'(st != 3));
        chk($sformatf("u%0d.done", i),         32'(dn),  32'(st == 3 && d == C + dly[i]));
        chk($sformatf("u%0d.boot_count", i),   32'(bcv), 32'(bc[i]));
    endtask

    task automatic check_all();
        check_one(0, bus0.reset_o, bus0.core_reset_o, bus0.done, bus0.boot_count, bus0.state);
        check_one(1, bus1.reset_o, bus1.core_reset_o, bus1.done, bus1.boot_count, bus1.state);
    endtask

    task automatic cycle(input bit req);
        bus0.reset_req = req;
        bus1.reset_req = req;
        @(posedge clk);
        model_edge(req);
        @(negedge clk);
        check_all();
    endtask

    // Called at a negedge: assert reset between edges, check immediately,
    // hold for a few cycles, then release at a negedge.
    task automatic do_reset(input int hold);
        reset  = 1'b0;
        in_rst = 1'b1;
        model_reset();
        #1;
        check_all();
        repeat (hold) cycle(1'b0);
        reset  = 1'b1;
        in_rst = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        in_rst         = 1'b1;
        bus0.reset_req = 1'b0;
        bus1.reset_req = 1'b0;
        model_reset();

        // Power-on: reset low 3 cycles, then the full release sequence.
        repeat (3) cycle(1'b0);
        reset  = 1'b1;
        in_rst = 1'b0;
        repeat (39) cycle(1'b0);
        cycle(1'b1);                 // single request at edge 40
        repeat (35) cycle(1'b0);

        // Request held over edges 40-45.
        do_reset(3);
        repeat (39) cycle(1'b0);
        repeat (6) cycle(1'b1);
        repeat (35) cycle(1'b0);

        // Async reset in HOLD_CORE after edge 24, then a clean rerun.
        do_reset(3);
        repeat (24) cycle(1'b0);
        do_reset(2);
        repeat (30) cycle(1'b0);

        // Random requests and occasional async resets.
        repeat (3000) begin
            if ($urandom_range(0, 399) == 0) do_reset(int'($urandom_range(1, 3)));
            else cycle($urandom_range(0, 15) == 0);
        end

        // Saturation of the boot counter via repeated re-boots.
        do_reset(2);
        repeat (30) cycle(1'b0);
        repeat (300) begin
            cycle(1'b1);
            repeat (25) cycle(1'b0);
        end

        // Requests during SYNC are ignored.
        do_reset(2);
        cycle(1'b1);
        cycle(1'b1);
        repeat (30) cycle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
